// File: rtl/axi_resp_fifo.sv
// axi_resp_fifo: AXI response-channel FIFO with first-word fall-through.
// One block serves two channels. B channel (USE_DATA=0): only ID and response
// are stored. R channel (USE_DATA=1): ID, response, data and last are stored.
// DEPTH may be any value from 2 to 256, and every entry is usable.
//
// Ports:
//   ACLK, ARESETn          clock; asynchronous active-low reset
//   flush                  synchronous clear of pointers, count and error flags
//   in_valid/in_ready      producer handshake; in_id, in_resp, in_data, in_last
//   out_valid/out_ready    consumer handshake; out_id, out_resp, out_data, out_last
//   count                  occupancy, 0..DEPTH
//   full, empty            status flags decoded from the registered count
//   almost_full            asserted when count >= AF_THRESH
//   err_ovf, err_udf       sticky: push while full / pop while empty
module axi_resp_fifo #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USE_DATA   = 0,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [1:0]            in_resp,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [1:0]            out_resp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic                ovf_q;
  logic                udf_q;
  logic                push;
  logic                pop;
  logic [ID_WIDTH-1:0] id_mem   [DEPTH];
  logic [1:0]          resp_mem [DEPTH];

  // The pointer wraps explicitly, so a DEPTH that is not a power of two
  // still uses every entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status flags come only from registers. There is no combinational path
  // from in_valid or out_ready to any status output.
  assign full        = (cnt == CW'(DEPTH));
  assign empty       = (cnt == '0);
  assign almost_full = (cnt >= CW'(AF_THRESH));
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign count       = cnt;
  assign err_ovf     = ovf_q;
  assign err_udf     = udf_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_id   = empty ? '0 : id_mem[rd_ptr];
  assign out_resp = empty ? '0 : resp_mem[rd_ptr];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        id_mem[i]   <= '0;
        resp_mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush takes priority over push and pop in the same cycle. The
      // handshake still completes on the ports, but the entry is dropped
      // and storage is left unchanged.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr]   <= in_id;
        resp_mem[wr_ptr] <= in_resp;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (in_valid && full) ovf_q <= 1'b1;
      if (out_ready && empty) udf_q <= 1'b1;
    end
  end

  if (USE_DATA != 0) begin : g_data
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic                  last_mem [DEPTH];

    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          data_mem[i] <= '0;
          last_mem[i] <= 1'b0;
        end
      end else if (push && !flush) begin
        data_mem[wr_ptr] <= in_data;
        last_mem[wr_ptr] <= in_last;
      end
    end

    assign out_data = empty ? '0 : data_mem[rd_ptr];
    assign out_last = empty ? 1'b0 : last_mem[rd_ptr];
  end else begin : g_nodata
    logic unused_data;
    assign unused_data = ^{in_data, in_last};
    assign out_data    = '0;
    assign out_last    = 1'b0;
  end

endmodule

// File: tb/tb_axi_resp_fifo.sv
// tb_axi_resp_fifo: directed bench for two configurations of axi_resp_fifo.
// Instance A is a B-channel FIFO with DEPTH=4 and USE_DATA=0.
// Instance B is an R-channel FIFO with DEPTH=3, USE_DATA=1 and AF_THRESH=2.
module tb_axi_resp_fifo;

  logic ACLK;
  logic ARESETn;

  // Instance A: DEPTH=4, USE_DATA=0
  logic        a_flush, a_in_valid, a_in_ready, a_in_last;
  logic [3:0]  a_in_id, a_out_id;
  logic [1:0]  a_in_resp, a_out_resp;
  logic [31:0] a_in_data, a_out_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [2:0]  a_count;
  logic        a_full, a_empty, a_af, a_err_ovf, a_err_udf;

  // Instance B: DEPTH=3, USE_DATA=1
  logic        b_flush, b_in_valid, b_in_ready, b_in_last;
  logic [3:0]  b_in_id, b_out_id;
  logic [1:0]  b_in_resp, b_out_resp;
  logic [7:0]  b_in_data, b_out_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [1:0]  b_count;
  logic        b_full, b_empty, b_af, b_err_ovf, b_err_udf;

  int passed = 0;
  int total  = 0;

  axi_resp_fifo #(
    .ID_WIDTH(4), .DATA_WIDTH(32), .USE_DATA(0), .DEPTH(4)
  ) dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_id(a_in_id),
    .in_resp(a_in_resp), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_id(a_out_id),
    .out_resp(a_out_resp), .out_data(a_out_data), .out_last(a_out_last),
    .count(a_count), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .err_ovf(a_err_ovf), .err_udf(a_err_udf)
  );

  axi_resp_fifo #(
    .ID_WIDTH(4), .DATA_WIDTH(8), .USE_DATA(1), .DEPTH(3), .AF_THRESH(2)
  ) dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_id(b_in_id),
    .in_resp(b_in_resp), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_id(b_out_id),
    .out_resp(b_out_resp), .out_data(b_out_data), .out_last(b_out_last),
    .count(b_count), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .err_ovf(b_err_ovf), .err_udf(b_err_udf)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic b_drive(input int i);
    b_in_id   = 4'(i);
    b_in_resp = 2'(i % 4);
    b_in_data = 8'(8'hA0 + i);
    b_in_last = ((i % 3) == 2);
  endtask

  initial begin
    int head;
    ARESETn = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_id = 0; a_in_resp = 0; a_in_data = 0;
    a_in_last = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_id = 0; b_in_resp = 0; b_in_data = 0;
    b_in_last = 0; b_out_ready = 0;

    // Reset state
    #3;
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_id", a_out_id, 0);
    check("rst_full", a_full, 0);
    check("rst_af", a_af, 0);
    check("rst_ovf", a_err_ovf, 0);
    check("rst_udf", a_err_udf, 0);
    check("rst_b_count", b_count, 0);
    check("rst_b_data", b_out_data, 0);
    #9 ARESETn = 1'b1;
    tick();

    // Fill A with IDs 1..4 and responses 0..3
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_id = 4'(i + 1); a_in_resp = 2'(i);
      tick();
      check("fill_count", a_count, 64'(i + 1));
      check("fill_af", a_af, (i >= 2));
      check("fill_full", a_full, (i == 3));
      check("fill_in_ready", a_in_ready, (i != 3));
      check("fill_head_id", a_out_id, 1);
    end
    check("fill_data_tied", a_out_data, 0);

    // Full FIFO: push and pop offered together, so only the pop happens
    a_in_id = 4'd5; a_in_resp = 2'd0; a_out_ready = 1;
    check("ovf_head_id", a_out_id, 1);
    check("ovf_head_resp", a_out_resp, 0);
    tick();
    check("ovf_count", a_count, 3);
    check("ovf_flag", a_err_ovf, 1);
    check("ovf_next_head", a_out_id, 2);
    a_out_ready = 0;
    tick();
    check("ovf_retry_count", a_count, 4);
    check("ovf_retry_full", a_full, 1);
    a_in_valid = 0;

    // Drain A: expected IDs 2,3,4,5 with responses 1,2,3,0
    a_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check("drain_id", a_out_id, 64'(k + 2));
      check("drain_resp", a_out_resp, 64'((k + 1) % 4));
      check("drain_last_tied", a_out_last, 0);
      tick();
      check("drain_count", a_count, 64'(3 - k));
    end
    check("drain_empty", a_empty, 1);
    check("drain_out_valid", a_out_valid, 0);
    // out_ready stays high while empty, which is an underflow
    tick();
    check("udf_flag", a_err_udf, 1);
    check("udf_count", a_count, 0);
    check("ovf_sticky", a_err_ovf, 1);
    a_out_ready = 0;

    // Push and pop in the same cycle with count=2
    a_in_valid = 1; a_in_id = 4'd6; a_in_resp = 2'd1;
    tick();
    a_in_id = 4'd7;
    tick();
    check("sim_pre_count", a_count, 2);
    a_in_id = 4'd8; a_in_resp = 2'd2; a_out_ready = 1;
    check("sim_pre_head", a_out_id, 6);
    tick();
    check("sim_count", a_count, 2);
    check("sim_head", a_out_id, 7);
    a_in_valid = 0;
    tick();
    check("sim_pop_count", a_count, 1);
    check("sim_tail_id", a_out_id, 8);
    check("sim_tail_resp", a_out_resp, 2);
    tick();
    a_out_ready = 0;
    check("sim_empty", a_empty, 1);

    // Flush with 3 entries while a push is offered
    a_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_id = 4'(9 + i); a_in_resp = 2'd0;
      tick();
    end
    check("fl_pre_count", a_count, 3);
    check("fl_pre_af", a_af, 1);
    a_flush = 1; a_in_id = 4'd12;
    tick();
    a_flush = 0;
    check("fl_count", a_count, 0);
    check("fl_empty", a_empty, 1);
    check("fl_out_id", a_out_id, 0);
    check("fl_ovf_clr", a_err_ovf, 0);
    check("fl_udf_clr", a_err_udf, 0);
    a_in_id = 4'd13; a_in_resp = 2'd3;
    tick();
    a_in_valid = 0;
    check("fl_after_count", a_count, 1);
    check("fl_after_id", a_out_id, 13);
    check("fl_after_resp", a_out_resp, 3);

    // B: DEPTH=3, 10 entries over several pointer wraps, occupancy held at 2
    b_in_valid = 1;
    b_drive(0);
    tick();
    b_drive(1);
    tick();
    check("b_count2", b_count, 2);
    check("b_af", b_af, 1);
    check("b_full", b_full, 0);
    head = 0;
    b_out_ready = 1;
    for (int i = 2; i < 10; i++) begin
      b_drive(i);
      check("b_id", b_out_id, 64'(head));
      check("b_data", b_out_data, 64'(8'hA0 + head));
      check("b_last", b_out_last, ((head % 3) == 2));
      check("b_resp", b_out_resp, 64'(head % 4));
      tick();
      head++;
      check("b_count_steady", b_count, 2);
    end
    b_in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      check("b_tail_data", b_out_data, 64'(8'hA0 + head));
      check("b_tail_last", b_out_last, ((head % 3) == 2));
      tick();
      head++;
    end
    b_out_ready = 0;
    check("b_empty", b_empty, 1);
    check("b_udf", b_err_udf, 0);
    check("b_empty_data", b_out_data, 0);

    // Asynchronous reset partway through a cycle
    a_in_valid = 1; a_in_id = 4'd14; a_in_resp = 2'd1;
    tick();
    a_in_valid = 0;
    check("ar_pre_count", a_count, 2);
    #2 ARESETn = 1'b0;
    #1;
    check("ar_count", a_count, 0);
    check("ar_out_valid", a_out_valid, 0);
    check("ar_out_id", a_out_id, 0);
    check("ar_in_ready", a_in_ready, 1);
    #3 ARESETn = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_resp_fifo.md
Name: axi_resp_fifo

Overview:
- Parametrised AXI response-channel FIFO; next generation of the crossbar's write-response pending buffer.
- Generalises the payload so one block serves both the B channel (DATA_WIDTH=0 path disabled via USE_DATA=0) and the R channel (RDATA+RLAST).
- Uses any DEPTH ≥ 2, not only powers of two, and all DEPTH entries are usable.
- Adds valid/ready handshakes on both sides, occupancy count, an almost-full threshold, synchronous flush and sticky overflow/underflow error flags. Sits between slave-side response ports and the master-side arbiter.

Parameters:
- ID_WIDTH, 4, width of response ID.
- DATA_WIDTH, 32, width of data payload; ignored when USE_DATA=0.
- USE_DATA, 0, 1 = store in_data/in_last (R channel); 0 = out_data/out_last tie to 0 (B channel).
- DEPTH, 4, number of entries; legal range 2..256.
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- CW, $clog2(DEPTH+1), derived count width.

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  FIFO accepts this cycle (= !full).
- in_id  in  ID_WIDTH  BID/RID.
- in_resp  in  2  BRESP/RRESP.
- in_data  in  DATA_WIDTH  RDATA.
- in_last  in  1  RLAST.
- out_valid  out  1  head entry valid (= !empty).
- out_ready  in  1  consumer takes head this cycle.
- out_id  out  ID_WIDTH  head ID.
- out_resp  out  2  head response.
- out_data  out  DATA_WIDTH  head data (0 when USE_DATA=0).
- out_last  out  1  head last (0 when USE_DATA=0).
- count  out  CW  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- err_ovf  out  1  sticky: in_valid while full.
- err_udf  out  1  sticky: out_ready while empty.

Behaviour:
- Reset (async assert, sync release on ARESETn):
  - wr_ptr, rd_ptr and count = 0; all storage = 0.
  - out_valid=0, in_ready=1, empty=1, full=0, almost_full=0 (or 1 if AF_THRESH==0, illegal); err_ovf=err_udf=0.
  - Reset during transfer discards all entries.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- First-word fall-through:
  - An entry pushed at edge N appears on out_* with out_valid=1 after edge N (1-cycle latency).
  - out_* are driven combinationally from storage[rd_ptr]; out_* = 0 content when empty.
- Pointers increment modulo DEPTH: from DEPTH-1 they wrap to 0, including for non-power-of-2 DEPTH.
- count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged, with write and read performed.
  - neither: unchanged.
- Full: in_ready=0, so push is impossible even when a pop occurs in the same cycle; that pop frees the slot for the next cycle.
- Empty: out_valid=0, so a pop is impossible. A push into an empty FIFO is not visible at the output until the next cycle (no combinational bypass).
- flush=1:
  - At the edge, pointers and count go to 0. Storage is untouched.
  - Flush overrides push/pop that cycle: the handshakes still occur on the ports, but the data is dropped.
  - Error flags are cleared by flush as well.
- err_ovf sets when in_valid & full. err_udf sets when out_ready & empty. Each holds until reset or flush.
- full, empty, almost_full and in_ready/out_valid are decoded from the registered count, so there are no combinational paths from in_valid/out_ready.

Test Plan:
- Reset, DEPTH=4 → count=0, empty=1, in_ready=1, out_valid=0, out_id=0, err flags 0.
- Push IDs 1,2,3,4 (resp 0,1,2,3) on back-to-back cycles → count 1,2,3,4; almost_full=1 at count 3; full=1 and in_ready=0 after the 4th push. Popping then yields IDs 1,2,3,4 in order with matching resp; empty=1 after the 4th pop.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle → ID 1 is popped, no push occurs, count=3, err_ovf=1. On the next cycle the push is accepted and count=4.
- DEPTH=3, USE_DATA=1, 10 pushes of data 0xA0+i with last=(i%3==2), interleaved with pops so occupancy stays 1–2 → output order and data are exact across multiple pointer wraps, and count never exceeds 3.
- Simultaneous push and pop with count=2 → count stays 2, the head advances, and the new entry appears at the tail in the correct order.
- Fill with 3 entries, assert flush together with in_valid=1 → count=0, empty=1, the pushed entry is dropped, err flags cleared. Asserting ARESETn low mid-burst clears outputs immediately, without waiting for a clock edge.
